// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM serial-to-parallel demultiplexer with frame-sync tracking.
// Rebuilds NUM_CH-slot frames from a serial sample stream and flags misalignment.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   din          serial sample for the current slot (DATA_W bits)
//   din_valid    din carries a sample this cycle
//   fsync        frame marker, high with the slot-0 sample
//   sel          slot index the next valid sample goes to
//   out          last complete frame, channel k at [k*DATA_W +: DATA_W]
//   frame_valid  one-cycle pulse when out is updated
//   locked       high while aligned to the frame marker
//   sync_err     one-cycle pulse on an alignment error
module tdm_demux4 #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     fsync,
  output logic [SEL_W-1:0]         sel,
  output logic [NUM_CH*DATA_W-1:0] out,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_t                     r_state;
  logic [SEL_W-1:0]           r_sel;
  logic [NUM_CH*DATA_W-1:0]   r_shadow;
  logic [NUM_CH*DATA_W-1:0]   r_out;
  logic                       r_fv;
  logic                       r_err;
  logic                       r_locked;

  logic                       w_first;
  logic                       w_last;
  logic                       w_early;
  logic                       w_miss;
  logic [NUM_CH*DATA_W-1:0]   w_frame;

  assign w_first = (r_sel == '0);
  assign w_last  = (r_sel == LAST);
  assign w_early = fsync && !w_first;
  assign w_miss  = !fsync && w_first;

  // Completed frame: the final slot comes straight from din on the
  // same edge, so out never shows a stale last channel.
  always_comb begin
    w_frame = r_shadow;
    w_frame[(NUM_CH-1)*DATA_W +: DATA_W] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HUNT;
      r_sel    <= '0;
      r_shadow <= '0;
      r_out    <= '0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_fv  <= 1'b0;
      r_err <= 1'b0;
      if (din_valid) begin
        unique case (r_state)
          HUNT: begin
            if (fsync) begin
              r_shadow[0 +: DATA_W] <= din;
              r_sel    <= ONE;
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end
          LOCKED: begin
            unique case (1'b1)
              w_early: begin
                // Marker arrived mid-frame: restart the frame here.
                r_err <= 1'b1;
                r_shadow[0 +: DATA_W] <= din;
                r_sel <= ONE;
              end
              w_miss: begin
                r_err    <= 1'b1;
                r_sel    <= '0;
                r_state  <= HUNT;
                r_locked <= 1'b0;
              end
              default: begin
                r_shadow[int'(r_sel)*DATA_W +: DATA_W] <= din;
                r_sel <= r_sel + ONE;
                if (w_last) begin
                  r_out <= w_frame;
                  r_fv  <= 1'b1;
                end
              end
            endcase
          end
          default: begin
            r_state <= HUNT;
          end
        endcase
      end
    end
  end

  assign sel         = r_sel;
  assign out         = r_out;
  assign frame_valid = r_fv;
  assign locked      = r_locked;
  assign sync_err    = r_err;

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer: receives a slot-sequenced serial sample stream, as produced by the team's 4:1 select-mux datapath stepping its select 0..3, and distributes the samples back into NUM_CH parallel channel registers.
- Tracks frame alignment with a frame-sync marker, publishes a complete parallel frame with a one-cycle valid pulse, and flags alignment errors.
- Sits at the receive end of the TDM link, directly after the serial line register.

Parameters:
- NUM_CH, 4, number of channels/slots per frame; must be a power of two, ≥2.
- SEL_W, 2, slot counter width; must equal log2(NUM_CH).
- DATA_W, 1, bits per channel sample.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  DATA_W  serial sample for the current slot.
- din_valid  input  1  din carries a sample this cycle.
- fsync  input  1  frame marker; high with the slot-0 sample. Ignored when din_valid=0.
- sel  output  SEL_W  slot index the next valid sample will be written to.
- out  output  NUM_CH*DATA_W  last complete frame; channel k at bits [k*DATA_W +: DATA_W].
- frame_valid  output  1  one-cycle pulse when out is updated.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on an alignment error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = HUNT; sel=0; out=0; shadow=0.
  - frame_valid=0; sync_err=0; locked=0.
  - Takes effect immediately and mid-frame; the partial frame is lost.
- All outputs are registered. No combinational path from inputs to outputs.
- State HUNT:
  - Samples are discarded until din_valid=1 and fsync=1.
  - On that edge: shadow[0] <= din; sel <= 1; state <= LOCKED; locked <= 1.
  - No sync_err while hunting.
- State LOCKED, on each din_valid=1 cycle:
  - Normal case (fsync=1 with sel==0, or fsync=0 with sel!=0): shadow[sel] <= din; sel <= sel+1, wrapping NUM_CH-1 -> 0.
  - Frame completion, sel==NUM_CH-1:
    - out <= shadow with slot NUM_CH-1 replaced by din (same edge).
    - frame_valid=1 for exactly the following cycle.
  - Early fsync (fsync=1, sel!=0):
    - sync_err pulse; partial frame discarded; no frame_valid.
    - The sample is taken as slot 0: shadow[0] <= din; sel <= 1; remain LOCKED.
  - Missing fsync (fsync=0, sel==0):
    - sync_err pulse; sample discarded.
    - state <= HUNT; sel <= 0; locked <= 0.
- din_valid=0 cycles (either state): no state change; gaps between samples of any length are allowed.
- out holds its value between frames and is never partially updated.
- shadow is internal and not visible on any port.
- NUM_CH=1 is not supported.
- frame_valid and sync_err are never high in the same cycle.

Test Plan:
- Reset mid-frame:
  - Stimulus: after 2 valid samples, pulse rst_n low between clock edges.
  - Response: out=0, sel=0, locked=0, frame_valid=0 immediately, without waiting for a clock edge.
- Basic frame (DATA_W=1):
  - Stimulus: samples 0,1,1,1 on consecutive valid cycles, fsync with the first.
  - Response: locked=1 after the first edge; sel steps 1,2,3,0; out=4'hE; frame_valid high exactly one cycle.
- Back-to-back frames with gaps:
  - Stimulus: frames 4'hA, 4'hC, 4'hB, each sample separated by 0-3 din_valid=0 cycles.
  - Response: three frame_valid pulses; out=A, then C, then B; no sync_err.
- Hunt ignores garbage:
  - Stimulus: 5 valid samples with fsync=0, then a correct frame 4'h0.
  - Response: locked=0 and no pulses during the garbage; then out=4'h0 with one frame_valid.
- Early fsync resync:
  - Stimulus: while locked, fsync arrives at sel=2, followed by a full frame 4'h5.
  - Response: sync_err one cycle; no frame_valid for the aborted frame; out=4'h5 on the next frame_valid; locked stays 1.
- Missing fsync:
  - Stimulus: while locked, the slot-0 sample arrives with fsync=0.
  - Response: sync_err one cycle; locked=0 and sel=0 next cycle; out unchanged.
